// File: rtl/lcd_char_status_ctrl.sv
// lcd_char_status_ctrl: HD44780-class character LCD controller. Runs power-on
// init, repaints changed value fields and a face glyph, and forwards host writes.
// Ports: clk, reset (async, active-high); values/face status inputs;
// cmd_valid/cmd_rs/cmd_data/cmd_ready host port; init_done, busy status;
// rs/rw/enable/data LCD pins. Define LCD_FORCE_REFRESH_EN to add the refresh input.
module lcd_char_status_ctrl #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BUS_W = 8,
    parameter int NUM_FIELDS = 3,
    parameter int VAL_W = 3,
    parameter int DIGITS = 1,
    parameter logic [8*NUM_FIELDS-1:0] FIELD_ADDR = {8'hCB, 8'h8F, 8'h89},
    parameter int FACE_W = 3,
    parameter logic [7:0] FACE_ADDR = 8'h80,
    parameter int POWERON_CYC = 2_000_000,
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC = 12,
    parameter int WAIT_CYC = 2_500,
    parameter int CLEAR_WAIT_CYC = 100_000
) (
    input  logic                        clk,
    input  logic                        reset,
`ifdef LCD_FORCE_REFRESH_EN
    input  logic                        refresh,
`endif
    input  logic [NUM_FIELDS*VAL_W-1:0] values,
    input  logic [FACE_W-1:0]           face,
    input  logic                        cmd_valid,
    input  logic                        cmd_rs,
    input  logic [7:0]                  cmd_data,
    output logic                        cmd_ready,
    output logic                        init_done,
    output logic                        busy,
    output logic                        rs,
    output logic                        rw,
    output logic                        enable,
    output logic [7:0]                  data
);
    localparam int NC = NUM_FIELDS + 1;
    localparam int N_INIT = (BUS_W == 4) ? 8 : 4;

    if (CLK_HZ < 1 || !(BUS_W == 4 || BUS_W == 8)) begin : g_param_err
        $error("lcd_char_status_ctrl: bad CLK_HZ or BUS_W");
    end

    typedef enum logic [2:0] {
        T_POWERON, T_INIT, T_IDLE, T_HOST,
        T_FIELD_ADDR, T_FIELD_DATA, T_FACE_ADDR, T_FACE_DATA
    } top_t;
    typedef enum logic [2:0] {E_IDLE, E_SETUP, E_PULSE, E_HOLD, E_WAIT} eng_t;

    top_t top;
    eng_t est;
    logic [31:0] pcnt, ecnt;
    logic [3:0] idx, rr, sel;
    logic [7:0] e_byte;
    logic e_single, e_hi, dlo, owe, any, go, go_rs, go_s, acc, eidle, e_clr;
    logic [7:0] go_b, fa;
    logic [VAL_W-1:0] shadow [NUM_FIELDS];
    logic [VAL_W-1:0] pval;
    logic [FACE_W-1:0] face_sh;
    logic [NC-1:0] frc, dirty;
    logic [31:0] wlen;
`ifdef LCD_FORCE_REFRESH_EN
    logic ref_q, ref_pend;
`endif

    // {single_nibble, byte}; single nibbles are sent from the high half only
    function automatic logic [8:0] init_word(input logic [3:0] i);
        if (BUS_W == 4) begin
            case (i)
                4'd0, 4'd1, 4'd2: return {1'b1, 8'h30};
                4'd3:             return {1'b1, 8'h20};
                4'd4:             return {1'b0, 8'h28};
                4'd5:             return {1'b0, 8'h0C};
                4'd6:             return {1'b0, 8'h06};
                default:          return {1'b0, 8'h01};
            endcase
        end else begin
            case (i)
                4'd0:    return {1'b0, 8'h38};
                4'd1:    return {1'b0, 8'h0C};
                4'd2:    return {1'b0, 8'h06};
                default: return {1'b0, 8'h01};
            endcase
        end
    endfunction

    function automatic int unsigned sat(input logic [VAL_W-1:0] v);
        int unsigned x;
        x = 32'(v);
        if (DIGITS == 2) return (x > 99) ? 99 : x;
        return (x > 9) ? 9 : x;
    endfunction

    function automatic logic [7:0] ch_hi(input logic [VAL_W-1:0] v);
        return 8'h30 + 8'(sat(v) / 10);
    endfunction

    function automatic logic [7:0] ch_lo(input logic [VAL_W-1:0] v);
        return 8'h30 + 8'(sat(v) % 10);
    endfunction

    assign rw = 1'b0;
    assign busy = (est != E_IDLE);
    assign eidle = (est == E_IDLE);
    assign cmd_ready = init_done && top == T_IDLE && eidle && !(owe && any);
    assign acc = cmd_valid && cmd_ready;
    assign e_clr = !rs && (e_byte == 8'h01 || e_byte == 8'h02);
    assign wlen = e_clr ? 32'(CLEAR_WAIT_CYC - 1) : 32'(WAIT_CYC - 1);

    always_comb begin
        for (int i = 0; i < NUM_FIELDS; i++)
            dirty[i] = frc[i] | (values[i*VAL_W +: VAL_W] != shadow[i]);
        dirty[NUM_FIELDS] = frc[NUM_FIELDS] | (face != face_sh);
    end

    // Round-robin: nearest dirty cell at or after rr wins
    always_comb begin
        int best;
        int d;
        best = NC;
        sel = '0;
        any = 1'b0;
        fa = FACE_ADDR;
        for (int i = 0; i < NC; i++) begin
            d = i - int'(rr);
            if (d < 0) d = d + NC;
            if (dirty[i] && d < best) begin
                best = d;
                sel = 4'(i);
                any = 1'b1;
            end
        end
        for (int i = 0; i < NUM_FIELDS; i++)
            if (sel == 4'(i)) fa = FIELD_ADDR[8*i +: 8];
    end

    // Byte to launch into the write engine this cycle, if any
    always_comb begin
        go = 1'b0;
        go_b = 8'h00;
        go_rs = 1'b0;
        go_s = 1'b0;
        case (top)
            T_POWERON: if (pcnt == 32'(POWERON_CYC - 1)) begin
                go = 1'b1;
                {go_s, go_b} = init_word(4'd0);
            end
            T_INIT: if (eidle && idx != 4'(N_INIT)) begin
                go = 1'b1;
                {go_s, go_b} = init_word(idx);
            end
            T_IDLE: if (acc) begin
                go = 1'b1;
                go_b = cmd_data;
                go_rs = cmd_rs;
            end else if (any) begin
                go = 1'b1;
                go_b = fa;
            end
            T_FIELD_ADDR: if (eidle) begin
                go = 1'b1;
                go_rs = 1'b1;
                go_b = (DIGITS == 2) ? ch_hi(pval) : ch_lo(pval);
            end
            T_FIELD_DATA: if (eidle && dlo) begin
                go = 1'b1;
                go_rs = 1'b1;
                go_b = ch_lo(pval);
            end
            T_FACE_ADDR: if (eidle) begin
                go = 1'b1;
                go_rs = 1'b1;
                go_b = 8'(face_sh);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top <= T_POWERON;
            est <= E_IDLE;
            pcnt <= '0;
            ecnt <= '0;
            idx <= '0;
            rr <= '0;
            e_byte <= '0;
            e_single <= 1'b0;
            e_hi <= 1'b0;
            dlo <= 1'b0;
            owe <= 1'b0;
            pval <= '0;
            face_sh <= '0;
            frc <= '1;
            for (int i = 0; i < NUM_FIELDS; i++) shadow[i] <= '0;
            init_done <= 1'b0;
            rs <= 1'b0;
            enable <= 1'b0;
            data <= '0;
`ifdef LCD_FORCE_REFRESH_EN
            ref_q <= 1'b0;
            ref_pend <= 1'b0;
`endif
        end else begin
            if (go) begin
                est <= E_SETUP;
                ecnt <= '0;
                e_byte <= go_b;
                e_single <= go_s;
                e_hi <= 1'b1;
                rs <= go_rs;
                data <= (BUS_W == 4) ? {go_b[7:4], 4'h0} : go_b;
            end else begin
                case (est)
                    E_SETUP: if (ecnt == 32'(SETUP_CYC - 1)) begin
                        est <= E_PULSE;
                        enable <= 1'b1;
                        ecnt <= '0;
                    end else ecnt <= ecnt + 1;
                    E_PULSE: if (ecnt == 32'(EN_CYC - 1)) begin
                        est <= E_HOLD;
                        enable <= 1'b0;
                        ecnt <= '0;
                    end else ecnt <= ecnt + 1;
                    E_HOLD: begin
                        ecnt <= '0;
                        if (BUS_W == 4 && e_hi && !e_single) begin
                            e_hi <= 1'b0;
                            data <= {e_byte[3:0], 4'h0};
                            est <= E_SETUP;
                        end else est <= E_WAIT;
                    end
                    E_WAIT: if (ecnt == wlen) est <= E_IDLE;
                        else ecnt <= ecnt + 1;
                    default: ;
                endcase
            end

            case (top)
                T_POWERON: begin
                    pcnt <= pcnt + 1;
                    if (go) begin
                        top <= T_INIT;
                        idx <= 4'd1;
                    end
                end
                T_INIT: if (eidle) begin
                    if (idx == 4'(N_INIT)) begin
                        init_done <= 1'b1;
                        top <= T_IDLE;
                    end else idx <= idx + 4'd1;
                end
                T_IDLE: if (acc) begin
                    owe <= 1'b1;
                    top <= T_HOST;
                    if (!cmd_rs && cmd_data == 8'h01) frc <= '1;
                end else if (any) begin
                    owe <= 1'b0;
                    rr <= (sel == 4'(NC - 1)) ? 4'd0 : sel + 4'd1;
                    for (int i = 0; i < NC; i++)
                        if (sel == 4'(i)) frc[i] <= 1'b0;
                    for (int i = 0; i < NUM_FIELDS; i++)
                        if (sel == 4'(i)) begin
                            shadow[i] <= values[i*VAL_W +: VAL_W];
                            pval <= values[i*VAL_W +: VAL_W];
                        end
                    if (sel == 4'(NUM_FIELDS)) begin
                        face_sh <= face;
                        top <= T_FACE_ADDR;
                    end else top <= T_FIELD_ADDR;
                end
                T_HOST: if (eidle) top <= T_IDLE;
                T_FIELD_ADDR: if (eidle) begin
                    top <= T_FIELD_DATA;
                    dlo <= (DIGITS == 2);
                end
                T_FIELD_DATA: if (eidle) begin
                    if (dlo) dlo <= 1'b0;
                    else top <= T_IDLE;
                end
                T_FACE_ADDR: if (eidle) top <= T_FACE_DATA;
                T_FACE_DATA: if (eidle) top <= T_IDLE;
                default: top <= T_POWERON;
            endcase

`ifdef LCD_FORCE_REFRESH_EN
            // Edges seen during init wait here until init_done
            ref_q <= refresh;
            if (init_done && ref_pend) begin
                frc <= '1;
                ref_pend <= 1'b0;
            end
            if (refresh && !ref_q) ref_pend <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_lcd_char_status_ctrl.sv
// tb_lcd_char_status_ctrl: scoreboard bench for lcd_char_status_ctrl,
// one 8-bit / 1-digit instance and one 4-bit / 2-digit instance.
module tb_lcd_char_status_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8, rst4;
    logic [8:0] values8;
    logic [2:0] face8;
    logic cv8, crs8;
    logic [7:0] cd8;
    logic rdy8, done8, busy8, rs8, rw8, en8;
    logic [7:0] data8;

    logic [20:0] values4;
    logic [2:0] face4;
    logic cv4, crs4;
    logic [7:0] cd4;
    logic rdy4, done4, busy4, rs4, rw4, en4;
    logic [7:0] data4;

    int checks = 0;
    int errors = 0;
    logic [8:0] q8[$];
    logic [8:0] q4[$];

    lcd_char_status_ctrl #(
        .BUS_W(8), .POWERON_CYC(20), .WAIT_CYC(10), .CLEAR_WAIT_CYC(30)
    ) u8 (
        .clk(clk), .reset(rst8),
`ifdef LCD_FORCE_REFRESH_EN
        .refresh(1'b0),
`endif
        .values(values8), .face(face8),
        .cmd_valid(cv8), .cmd_rs(crs8), .cmd_data(cd8), .cmd_ready(rdy8),
        .init_done(done8), .busy(busy8), .rs(rs8), .rw(rw8),
        .enable(en8), .data(data8)
    );

    lcd_char_status_ctrl #(
        .BUS_W(4), .VAL_W(7), .DIGITS(2),
        .POWERON_CYC(20), .WAIT_CYC(10), .CLEAR_WAIT_CYC(30)
    ) u4 (
        .clk(clk), .reset(rst4),
`ifdef LCD_FORCE_REFRESH_EN
        .refresh(1'b0),
`endif
        .values(values4), .face(face4),
        .cmd_valid(cv4), .cmd_rs(crs4), .cmd_data(cd4), .cmd_ready(rdy4),
        .init_done(done4), .busy(busy4), .rs(rs4), .rw(rw4),
        .enable(en4), .data(data4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic p8(input logic r, input logic [7:0] b);
        q8.push_back({r, b});
    endtask

    task automatic p4(input logic r, input logic [7:0] b);
        q4.push_back({r, b[7:4], 4'h0});
        q4.push_back({r, b[3:0], 4'h0});
    endtask

    task automatic p4n(input logic [7:0] b);
        q4.push_back({1'b0, b[7:4], 4'h0});
    endtask

    task automatic init8();
        p8(0, 8'h38); p8(0, 8'h0C); p8(0, 8'h06); p8(0, 8'h01);
    endtask

    // Writes are observed on enable falling edges
    logic pe8 = 1'b0, pe4 = 1'b0;
    int hi4 = 0;
    always @(negedge clk) begin
        if (rst8) pe8 = 1'b0;
        else begin
            if (pe8 && !en8) begin
                if (q8.size() == 0) chk("extra8", 32'({rs8, data8}), 32'h1FF);
                else chk("wr8", 32'({rs8, data8}), 32'(q8.pop_front()));
            end
            pe8 = en8;
        end
    end

    always @(negedge clk) begin
        if (rst4) begin
            pe4 = 1'b0;
            hi4 = 0;
        end else begin
            if (en4) hi4++;
            if (pe4 && !en4) begin
                chk("en_width4", 32'(hi4), 32'd12);
                chk("low_nib4", 32'(data4[3:0]), 32'd0);
                if (q4.size() == 0) chk("extra4", 32'({rs4, data4}), 32'h1FF);
                else chk("wr4", 32'({rs4, data4}), 32'(q4.pop_front()));
                hi4 = 0;
            end
            pe4 = en4;
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 5000), 32'd1);
        repeat (60) @(negedge clk);
    endtask

    task automatic host_send(input logic r, input logic [7:0] b);
        int n;
        cv8 = 1'b1;
        crs8 = r;
        cd8 = b;
        n = 0;
        #1;
        while (!rdy8 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("host_rdy_timeout", 32'(n < 3000), 32'd1);
        @(negedge clk);
        #1;
        chk("rdy_drop", 32'(rdy8), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst8 = 1'b1;
        rst4 = 1'b1;
        values8 = {3'd7, 3'd5, 3'd5};
        face8 = 3'd3;
        cv8 = 1'b0; crs8 = 1'b0; cd8 = 8'h00;
        values4 = {7'd42, 7'd7, 7'd127};
        face4 = 3'd0;
        cv4 = 1'b0; crs4 = 1'b0; cd4 = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(en8), 32'd0);
        chk("rst_data", 32'(data8), 32'd0);
        chk("rst_rs", 32'({rs8, rw8}), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_busy", 32'({busy8, busy4}), 32'd0);

        init8();
        p8(0, 8'h89); p8(1, 8'h35);
        p8(0, 8'h8F); p8(1, 8'h35);
        p8(0, 8'hCB); p8(1, 8'h37);
        p8(0, 8'h80); p8(1, 8'h03);
        p4n(8'h30); p4n(8'h30); p4n(8'h30); p4n(8'h20);
        p4(0, 8'h28); p4(0, 8'h0C); p4(0, 8'h06); p4(0, 8'h01);
        p4(0, 8'h89); p4(1, 8'h39); p4(1, 8'h39);
        p4(0, 8'h8F); p4(1, 8'h30); p4(1, 8'h37);
        p4(0, 8'hCB); p4(1, 8'h34); p4(1, 8'h32);
        p4(0, 8'h80); p4(1, 8'h00);
        rst8 = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);
        chk("done_early", 32'(done8), 32'd0);
        chk("rdy_init", 32'(rdy8), 32'd0);
        drain();
        chk("init_done8", 32'(done8), 32'd1);
        chk("init_done4", 32'(done4), 32'd1);
        chk("idle_busy", 32'(busy8), 32'd0);

        // single field change paints only that cell
        values8[5:3] = 3'd2;
        p8(0, 8'h8F); p8(1, 8'h32);
        values4[20:14] = 7'd100;
        p4(0, 8'hCB); p4(1, 8'h39); p4(1, 8'h39);
        drain();

        // host held valid while all fields change: alternate
        p8(1, 8'h41); p8(0, 8'hCB); p8(1, 8'h34);
        p8(1, 8'h42); p8(0, 8'h89); p8(1, 8'h31);
        p8(1, 8'h43); p8(0, 8'h8F); p8(1, 8'h33);
        values8 = {3'd4, 3'd3, 3'd1};
        host_send(1'b1, 8'h41);
        host_send(1'b1, 8'h42);
        host_send(1'b1, 8'h43);
        cv8 = 1'b0;
        drain();

        // clear command repaints everything
        p8(0, 8'h01);
        p8(0, 8'hCB); p8(1, 8'h34);
        p8(0, 8'h80); p8(1, 8'h03);
        p8(0, 8'h89); p8(1, 8'h31);
        p8(0, 8'h8F); p8(1, 8'h33);
        host_send(1'b0, 8'h01);
        cv8 = 1'b0;
        drain();
        chk("rdy_after", 32'(rdy8), 32'd1);

        // reset during enable pulse
        face8 = 3'd5;
        p8(0, 8'h80); p8(1, 8'h05);
        n = 0;
        while (!en8 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_timeout", 32'(n < 2000), 32'd1);
        #2 rst8 = 1'b1;
        #1;
        chk("rst_mid_en", 32'(en8), 32'd0);
        chk("rst_mid_done", 32'(done8), 32'd0);
        q8.delete();
        repeat (3) @(negedge clk);
        init8();
        p8(0, 8'h89); p8(1, 8'h31);
        p8(0, 8'h8F); p8(1, 8'h33);
        p8(0, 8'hCB); p8(1, 8'h34);
        p8(0, 8'h80); p8(1, 8'h05);
        rst8 = 1'b0;
        drain();
        chk("reinit_done", 32'(done8), 32'd1);
        chk("q_empty", 32'(q8.size() + q4.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
